// File: rtl/aes_pkg.sv
// Shared AES typedefs, geometry constants and the InvShiftRows index helper.
package aes_pkg;

  typedef logic [7:0]       byte_t;
  typedef logic [31:0]      word_t;
  // Index c holds column c. Byte [31:24] of a column is row 0.
  typedef logic [3:0][31:0] state_t;

  localparam int NCOL = 4;
  localparam int NROW = 4;

  // InvShiftRows rotates row r right by r, so output column c row r
  // takes its byte from input column (c - r) mod 4.
  function automatic int isr_src_col(int c, int r);
    return (c - r + NCOL) % NCOL;
  endfunction

  // Bit offset of row r inside a 32-bit column word.
  function automatic int row_lsb(int r);
    return 8 * (NROW - 1 - r);
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box: purely combinational 256-entry byte lookup.
module inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  // Entry 0x00 sits in the top byte, so the lookup index is ~a_i.
  localparam logic [255:0][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Table read.
  always_comb begin
    y_o = INV_SBOX[~a_i];
  end

endmodule

// File: rtl/inv_final_round.sv
// AES-128 last inverse round: InvShiftRows + InvSubBytes (stage 1), then
// AddRoundKey with the round-0 key from key RAM (stage 2). Valid/ready on
// both sides, full throughput, registered outputs.
module inv_final_round
  import aes_pkg::*;
#(
  parameter int KEY_ADDR = 0,
  parameter int RAM_AW   = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  output logic [RAM_AW-1:0] oRAM_addr,
  output logic              oRAM_rden,
  input  logic [31:0]       iRAM_data_1,
  input  logic [31:0]       iRAM_data_2,
  input  logic [31:0]       iRAM_data_3,
  input  logic [31:0]       iRAM_data_4,
  input  logic              iData_valid,
  output logic              oData_ready,
  input  logic [31:0]       iData_1,
  input  logic [31:0]       iData_2,
  input  logic [31:0]       iData_3,
  input  logic [31:0]       iData_4,
  output logic              oData_valid,
  input  logic              iData_ready,
  output logic [31:0]       oData_1,
  output logic [31:0]       oData_2,
  output logic [31:0]       oData_3,
  output logic [31:0]       oData_4
);

  state_t in_st, sb_st, key_st;
  state_t s1_state_q, s2_state_q;
  logic   s1_valid_q, s2_valid_q, rden_q;
  logic   s1_valid_d, s2_valid_d;
  logic   adv1, adv2, accept, xfer;

  // The key address never changes, so the RAM word stays put after the
  // first read; the strobe is only a per-input read indication.
  assign oRAM_addr = RAM_AW'(KEY_ADDR);
  assign oRAM_rden = rden_q;

  assign in_st  = {iData_4, iData_3, iData_2, iData_1};
  assign key_st = {iRAM_data_4, iRAM_data_3, iRAM_data_2, iRAM_data_1};

  // Byte lanes: InvShiftRows is pure wiring in front of each S-box.
  for (genvar c = 0; c < NCOL; c++) begin : g_col
    for (genvar r = 0; r < NROW; r++) begin : g_row
      localparam int SC  = isr_src_col(c, r);
      localparam int LSB = row_lsb(r);
      inv_sbox u_sbox (
        .a_i (in_st[SC][LSB +: 8]),
        .y_o (sb_st[c][LSB +: 8])
      );
    end
  end

  // Handshake: a stage moves when the stage after it is empty or draining.
  always_comb begin
    adv2        = !s2_valid_q || iData_ready;
    adv1        = s1_valid_q && adv2;
    oData_ready = !s1_valid_q || adv1;
    accept      = iData_valid && oData_ready;
    xfer        = s2_valid_q && iData_ready;
    s1_valid_d  = s1_valid_q;
    s2_valid_d  = s2_valid_q;
    if (accept)    s1_valid_d = 1'b1;
    else if (adv1) s1_valid_d = 1'b0;
    if (adv1)      s2_valid_d = 1'b1;
    else if (xfer) s2_valid_d = 1'b0;
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      rden_q     <= 1'b0;
      s1_state_q <= '0;
      s2_state_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      rden_q     <= accept;
      if (accept) s1_state_q <= sb_st;
      if (adv1)   s2_state_q <= s1_state_q ^ key_st;
    end
  end

  assign oData_valid = s2_valid_q;
  assign oData_1     = s2_state_q[0];
  assign oData_2     = s2_state_q[1];
  assign oData_3     = s2_state_q[2];
  assign oData_4     = s2_state_q[3];

endmodule

// File: tb/tb_inv_final_round.sv
// Directed bench for inv_final_round: FIPS-197 vector, streaming,
// backpressure, key-only, mid-flight reset and key-RAM strobe counting.
module tb_inv_final_round;

  localparam int KEY_ADDR = 5;
  localparam int RAM_AW   = 4;
  localparam logic [127:0] KEY    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_IN  = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [127:0] C1_OUT = 128'h00112233445566778899aabbccddeeff;

  logic              iClk = 1'b0;
  logic              iRst;
  logic [RAM_AW-1:0] oRAM_addr;
  logic              oRAM_rden;
  logic [31:0]       iRAM_data_1, iRAM_data_2, iRAM_data_3, iRAM_data_4;
  logic              iData_valid, oData_ready, oData_valid, iData_ready;
  logic [31:0]       iData_1, iData_2, iData_3, iData_4;
  logic [31:0]       oData_1, oData_2, oData_3, oData_4;
  logic [127:0]      obs;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_rden  = 0;

  // Forward S-box of 0..7: the inverse S-box maps these back to 0..7.
  logic [7:0] fwd [0:7] = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5};

  inv_final_round #(.KEY_ADDR(KEY_ADDR), .RAM_AW(RAM_AW)) dut (
    .iClk(iClk), .iRst(iRst), .oRAM_addr(oRAM_addr), .oRAM_rden(oRAM_rden),
    .iRAM_data_1(iRAM_data_1), .iRAM_data_2(iRAM_data_2),
    .iRAM_data_3(iRAM_data_3), .iRAM_data_4(iRAM_data_4),
    .iData_valid(iData_valid), .oData_ready(oData_ready),
    .iData_1(iData_1), .iData_2(iData_2), .iData_3(iData_3), .iData_4(iData_4),
    .oData_valid(oData_valid), .iData_ready(iData_ready),
    .oData_1(oData_1), .oData_2(oData_2), .oData_3(oData_3), .oData_4(oData_4)
  );

  always #5 iClk = ~iClk;

  assign obs = {oData_1, oData_2, oData_3, oData_4};

  // Inputs and state are stable at the falling edge, so count handshakes there.
  always @(negedge iClk) begin
    if (!iRst && iData_valid && oData_ready) n_acc++;
    if (oRAM_rden) n_rden++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge iClk);
    #1;
  endtask

  task automatic set_in(input logic [127:0] s);
    {iData_1, iData_2, iData_3, iData_4} = s;
  endtask

  task automatic set_key(input logic [127:0] k);
    {iRAM_data_1, iRAM_data_2, iRAM_data_3, iRAM_data_4} = k;
  endtask

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [127:0] s_in(input int k);
    return {16{fwd[k]}};
  endfunction

  function automatic logic [127:0] s_exp(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {16{b}} ^ KEY;
  endfunction

  initial begin
    iRst = 1'b1; iData_valid = 1'b0; iData_ready = 1'b1;
    set_in('0); set_key(KEY);

    // Reset state
    cyc(); cyc();
    @(negedge iClk);
    chk("rst_valid", 128'(oData_valid), 128'd0);
    chk("rst_data",  obs, 128'd0);
    chk("rst_rden",  128'(oRAM_rden), 128'd0);
    chk("rst_addr",  128'(oRAM_addr), 128'(KEY_ADDR));
    cyc(); iRst = 1'b0;
    @(negedge iClk);
    chk("rel_ready", 128'(oData_ready), 128'd1);
    chk("rel_valid", 128'(oData_valid), 128'd0);

    // FIPS-197 C.1 final inverse round, 2-cycle latency
    cyc(); iData_valid = 1'b1; set_in(C1_IN);
    cyc(); iData_valid = 1'b0;
    @(negedge iClk);
    chk("c1_lat1_valid", 128'(oData_valid), 128'd0);
    chk("c1_rden",       128'(oRAM_rden), 128'd1);
    cyc();
    @(negedge iClk);
    chk("c1_valid", 128'(oData_valid), 128'd1);
    chk("c1_data",  obs, C1_OUT);
    chk("c1_rden_off", 128'(oRAM_rden), 128'd0);
    cyc();
    @(negedge iClk);
    chk("c1_drain", 128'(oData_valid), 128'd0);

    // Back-to-back streaming of 8 states
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i < 8) begin iData_valid = 1'b1; set_in(s_in(i)); end
      else iData_valid = 1'b0;
      @(negedge iClk);
      if (i < 8) chk("str_ready", 128'(oData_ready), 128'd1);
      if (i >= 2) begin
        chk("str_valid", 128'(oData_valid), 128'd1);
        chk("str_data",  obs, s_exp(i - 2));
      end
    end
    cyc();
    @(negedge iClk);
    chk("str_drain", 128'(oData_valid), 128'd0);

    // Backpressure: 5 cycles of iData_ready=0 while offering 3 states
    cyc(); iData_ready = 1'b0; iData_valid = 1'b1; set_in(s_in(0));
    @(negedge iClk); chk("bp_ready0", 128'(oData_ready), 128'd1);
    cyc(); set_in(s_in(1));
    @(negedge iClk); chk("bp_ready1", 128'(oData_ready), 128'd1);
    cyc(); set_in(s_in(2));
    @(negedge iClk);
    chk("bp_full_ready", 128'(oData_ready), 128'd0);
    chk("bp_valid",      128'(oData_valid), 128'd1);
    chk("bp_hold",       obs, s_exp(0));
    for (int h = 0; h < 2; h++) begin
      cyc();
      @(negedge iClk);
      chk("bp_hold_ready", 128'(oData_ready), 128'd0);
      chk("bp_hold_data",  obs, s_exp(0));
    end
    cyc(); iData_ready = 1'b1;
    @(negedge iClk);
    chk("bp_rel_ready", 128'(oData_ready), 128'd1);
    chk("bp_out0",      obs, s_exp(0));
    cyc(); iData_valid = 1'b0;
    @(negedge iClk);
    chk("bp_v1",   128'(oData_valid), 128'd1);
    chk("bp_out1", obs, s_exp(1));
    cyc();
    @(negedge iClk);
    chk("bp_v2",   128'(oData_valid), 128'd1);
    chk("bp_out2", obs, s_exp(2));
    cyc();
    @(negedge iClk);
    chk("bp_drain", 128'(oData_valid), 128'd0);

    // Key-only: 0x63 -> 0x00 then ^ff; 0x52 -> 0x48 then ^ff = b7
    set_key({4{32'hffffffff}});
    cyc(); iData_valid = 1'b1; set_in({16{8'h63}});
    cyc(); set_in({16{8'h52}});
    cyc(); iData_valid = 1'b0;
    @(negedge iClk);
    chk("key_ff", obs, {4{32'hffffffff}});
    cyc();
    @(negedge iClk);
    chk("key_b7", obs, {16{8'hb7}});
    cyc(); set_key(KEY);

    // Reset with both stages occupied
    iData_ready = 1'b0;
    cyc(); iData_valid = 1'b1; set_in(s_in(3));
    cyc(); set_in(s_in(4));
    cyc(); iData_valid = 1'b0;
    @(negedge iClk);
    chk("mr_full_valid", 128'(oData_valid), 128'd1);
    chk("mr_full_ready", 128'(oData_ready), 128'd0);
    cyc(); iRst = 1'b1;
    cyc(); iRst = 1'b0;
    @(negedge iClk);
    chk("mr_valid", 128'(oData_valid), 128'd0);
    chk("mr_data",  obs, 128'd0);
    chk("mr_ready", 128'(oData_ready), 128'd1);
    iData_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      cyc();
      @(negedge iClk);
      chk("mr_ghost", 128'(oData_valid), 128'd0);
    end

    // RAM interface: 1 + 8 + 3 + 2 + 2 accepted inputs, one strobe each
    cyc(); cyc();
    @(negedge iClk);
    chk("acc_count",  128'(n_acc),  128'd16);
    chk("rden_count", 128'(n_rden), 128'd16);
    chk("addr_end",   128'(oRAM_addr), 128'(KEY_ADDR));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
